// File: rtl/seq_det_sched.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_sched
// Description : Round-robin scheduler sharing one "0111" detector across NCH
//               serial channels. Each channel keeps a 2-bit saved context that
//               is swapped into the shared next-state logic when granted.
//               Optional build macro SEQ_SCHED_CNT_EN adds per-channel
//               saturating 8-bit match counters readable through cnt_sel.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_det_sched #(
  parameter int NCH = 4,
  parameter int CHW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] ch_valid,
  input  logic [NCH-1:0] ch_bit,
  input  logic [NCH-1:0] ch_clr,
  output logic [NCH-1:0] ch_ready,
  output logic           match_valid,
  output logic [CHW-1:0] match_ch,
  output logic           busy,
  input  logic [CHW-1:0] cnt_sel,
  output logic [7:0]     cnt_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G01  = 2'd2,
    G011 = 2'd3
  } state_t;

  state_t         ctx_q [NCH];
  state_t         ctx_d [NCH];
  logic [CHW-1:0] ptr_q, ptr_d;
  logic           match_valid_q, match_valid_d;
  logic [CHW-1:0] match_ch_q, match_ch_d;
  logic           busy_q, busy_d;

  logic [NCH-1:0] w_elig;
  logic           w_gnt_vld;
  logic [CHW-1:0] w_gnt_id;
  logic           w_bit;
  state_t         w_cur;
  state_t         w_nxt;
  logic           w_hit;

  // A channel being cleared never competes, so its bit is never consumed.
  assign w_elig = ch_valid & ~ch_clr;

  // Arbiter: first eligible channel searching upward from ptr, with wrap
  always_comb begin
    logic [CHW:0]   sum;
    logic [CHW-1:0] idx;
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < NCH; k++) begin
      sum = {1'b0, ptr_q} + (CHW+1)'(k);
      if (sum >= (CHW+1)'(NCH)) begin
        sum = sum - (CHW+1)'(NCH);
      end
      idx = sum[CHW-1:0];
      if (!w_gnt_vld && w_elig[idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = idx;
      end
    end
  end

  // One-hot grant decode
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ready
      assign ch_ready[gi] = w_gnt_vld && (w_gnt_id == CHW'(gi));
    end
  endgenerate

  assign w_bit = ch_bit[w_gnt_id];
  assign w_cur = ctx_q[w_gnt_id];

  // Shared detector transition for the context currently swapped in
  always_comb begin
    w_nxt = IDLE;
    w_hit = 1'b0;
    case (w_cur)
      IDLE:    w_nxt = w_bit ? IDLE : G0;
      G0:      w_nxt = w_bit ? G01  : G0;
      G01:     w_nxt = w_bit ? G011 : G0;
      G011: begin
        if (w_bit) begin
          w_nxt = IDLE;     // non-overlapping: restart after a match
          w_hit = 1'b1;
        end else begin
          w_nxt = G0;
        end
      end
      default: w_nxt = IDLE;
    endcase
  end

  // Context write-back, pointer advance, match and busy next values
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      ctx_d[i] = ctx_q[i];
      if (ch_clr[i]) begin
        ctx_d[i] = IDLE;
      end else if (w_gnt_vld && (w_gnt_id == CHW'(i))) begin
        ctx_d[i] = w_nxt;
      end
    end

    ptr_d = ptr_q;
    if (w_gnt_vld) begin
      ptr_d = (w_gnt_id == CHW'(NCH-1)) ? '0 : w_gnt_id + CHW'(1);
    end

    match_valid_d = w_gnt_vld & w_hit;
    match_ch_d    = match_valid_d ? w_gnt_id : match_ch_q;

    busy_d = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (ctx_d[i] != IDLE) begin
        busy_d = 1'b1;
      end
    end
  end

  // State registers; reset drops every partial sequence and any pending match
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        ctx_q[i] <= IDLE;
      end
      ptr_q         <= '0;
      match_valid_q <= 1'b0;
      match_ch_q    <= '0;
      busy_q        <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        ctx_q[i] <= ctx_d[i];
      end
      ptr_q         <= ptr_d;
      match_valid_q <= match_valid_d;
      match_ch_q    <= match_ch_d;
      busy_q        <= busy_d;
    end
  end

  assign match_valid = match_valid_q;
  assign match_ch    = match_ch_q;
  assign busy        = busy_q;

`ifdef SEQ_SCHED_CNT_EN
  logic [7:0] cnt_q [NCH];
  logic [7:0] cnt_d [NCH];

  // Counters step on the same edge that raises match_valid; clear wins
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (ch_clr[i]) begin
        cnt_d[i] = 8'd0;
      end else if (match_valid_d && (w_gnt_id == CHW'(i)) && (cnt_q[i] != 8'hFF)) begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Combinational counter read mux
  always_comb begin
    cnt_out = 8'd0;
    for (int i = 0; i < NCH; i++) begin
      if (cnt_sel == CHW'(i)) begin
        cnt_out = cnt_q[i];
      end
    end
  end
`else
  logic w_unused_cnt_sel;
  assign w_unused_cnt_sel = ^cnt_sel;
  assign cnt_out          = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_det_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_det_sched
// Description : Scoreboard bench for seq_det_sched. Stimulus pushes expected
//               match events (channel id and arrival cycle); a monitor pops
//               and compares whenever match_valid is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_det_sched;
  localparam int NCH = 4;
  localparam int CHW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] ch_valid;
  logic [NCH-1:0] ch_bit;
  logic [NCH-1:0] ch_clr;
  logic [NCH-1:0] ch_ready;
  logic           match_valid;
  logic [CHW-1:0] match_ch;
  logic           busy;
  logic [CHW-1:0] cnt_sel;
  logic [7:0]     cnt_out;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    int id;
    int cyc;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  seq_det_sched #(.NCH(NCH), .CHW(CHW)) dut (
    .clk        (clk),
    .rst        (rst),
    .ch_valid   (ch_valid),
    .ch_bit     (ch_bit),
    .ch_clr     (ch_clr),
    .ch_ready   (ch_ready),
    .match_valid(match_valid),
    .match_ch   (match_ch),
    .busy       (busy),
    .cnt_sel    (cnt_sel),
    .cnt_out    (cnt_out)
  );

  always #5 clk = ~clk;

  // Count rising edges so expected matches carry an arrival cycle
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every match pulse must be the next expected event, on time
  always @(negedge clk) begin
    if (match_valid === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_match: got ch %0d at cycle %0d, required no match", match_ch, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.id != int'(match_ch) || mon_e.cyc != cyc) begin
          n_bad++;
          $display("FAIL match: got ch %0d at cycle %0d, required ch %0d at cycle %0d",
                   match_ch, cyc, mon_e.id, mon_e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // One stimulus cycle: drive at negedge, check grant, let the edge accept
  task automatic step(input logic [NCH-1:0] v, input logic [NCH-1:0] b,
                      input logic [NCH-1:0] c, input logic [NCH-1:0] rdy_exp,
                      input bit m, input int mid, input string name);
    @(negedge clk);
    ch_valid = v;
    ch_bit   = b;
    ch_clr   = c;
    #1;
    check(name, 32'(ch_ready), 32'(rdy_exp));
    if (m) exp_q.push_back('{mid, cyc + 1});
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step('0, '0, '0, '0, 1'b0, 0, "idle_ready");
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst      = 1'b1;
    ch_valid = '0;
    ch_bit   = '0;
    ch_clr   = '0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_match_valid", 32'(match_valid), 0);
    check("rst_match_ch", 32'(match_ch), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(ch_ready), 0);
    check("rst_cnt_out", 32'(cnt_out), 0);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pos[NCH];
    rst      = 1'b1;
    ch_valid = '0;
    ch_bit   = '0;
    ch_clr   = '0;
    cnt_sel  = '0;
    do_reset(2);

    // Channel 0 alone: 0,1,1,1 -> one match on ch 0
    step(4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0, 0, "c0_b0");
    #1 check("busy_mid", 32'(busy), 1);
    step(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b0, 0, "c0_b1");
    step(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b0, 0, "c0_b2");
    step(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1, 0, "c0_b3");
    #1 check("busy_after_c0", 32'(busy), 0);
    idle(2);

    // All four channels: grant order 0,1,2,3 repeating, matches 0..3 back-to-back
    do_reset(1);
    for (int i = 0; i < NCH; i++) pos[i] = 0;
    for (int k = 0; k < 16; k++) begin
      logic [NCH-1:0] v;
      logic [NCH-1:0] b;
      int g;
      g = k % NCH;
      v = '0;
      b = '0;
      for (int i = 0; i < NCH; i++) begin
        if (pos[i] < 4) begin
          v[i] = 1'b1;
          b[i] = (pos[i] != 0);
        end
      end
      step(v, b, '0, NCH'(1) << g, pos[g] == 3, g, "rr_grant");
      pos[g]++;
    end
    idle(2);

    // Channel 2: 0,1,1,1,1,1 -> exactly one match, ends IDLE
    step(4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b0, 2, "c2_b0");
    step(4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b0, 2, "c2_b1");
    step(4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b0, 2, "c2_b2");
    step(4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b1, 2, "c2_b3");
    step(4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b0, 2, "c2_b4");
    step(4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b0, 2, "c2_b5");
    #1 check("busy_after_c2", 32'(busy), 0);
    idle(2);

    // Channel 1: 0,1,1, clear (masked), 1 -> no match; clear on ch 3 harmless
    step(4'b0010, 4'b0000, 4'b1000, 4'b0010, 1'b0, 0, "c1_clr_other");
    step(4'b0010, 4'b0010, 4'b0000, 4'b0010, 1'b0, 0, "c1_b1");
    step(4'b0010, 4'b0010, 4'b0000, 4'b0010, 1'b0, 0, "c1_b2");
    #1 check("busy_before_clr", 32'(busy), 1);
    step(4'b0010, 4'b0010, 4'b0010, 4'b0000, 1'b0, 0, "c1_clr_mask");
    #1 check("busy_after_clr", 32'(busy), 0);
    step(4'b0010, 4'b0010, 4'b0000, 4'b0010, 1'b0, 0, "c1_b3");
    idle(2);

    // Channel 3: 0,1,1, reset, then 1 -> no match
    step(4'b1000, 4'b0000, 4'b0000, 4'b1000, 1'b0, 0, "c3_b0");
    step(4'b1000, 4'b1000, 4'b0000, 4'b1000, 1'b0, 0, "c3_b1");
    step(4'b1000, 4'b1000, 4'b0000, 4'b1000, 1'b0, 0, "c3_b2");
    do_reset(2);
    step(4'b1000, 4'b1000, 4'b0000, 4'b1000, 1'b0, 0, "c3_post_rst");
    idle(2);

    // Channel 3: 0,1,1, then the completing bit lands in a reset cycle
    step(4'b1000, 4'b0000, 4'b0000, 4'b1000, 1'b0, 0, "c3r_b0");
    step(4'b1000, 4'b1000, 4'b0000, 4'b1000, 1'b0, 0, "c3r_b1");
    step(4'b1000, 4'b1000, 4'b0000, 4'b1000, 1'b0, 0, "c3r_b2");
    @(negedge clk);
    rst      = 1'b1;
    ch_valid = 4'b1000;
    ch_bit   = 4'b1000;
    @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    ch_valid = '0;
    ch_bit   = '0;
    #1 check("busy_after_rst_bit", 32'(busy), 0);
    idle(3);

    // Wrap and pointer hold: ch 0 and ch 3 contend (ptr is 0 after reset)
    step(4'b1001, 4'b0000, 4'b0000, 4'b0001, 1'b0, 0, "wrap_a");
    step(4'b1001, 4'b0000, 4'b0000, 4'b1000, 1'b0, 0, "wrap_b");
    step(4'b1001, 4'b0000, 4'b0000, 4'b0001, 1'b0, 0, "wrap_c");
    idle(1);
    step(4'b1001, 4'b0000, 4'b0000, 4'b1000, 1'b0, 0, "hold_ptr");
    idle(2);

`ifdef SEQ_SCHED_CNT_EN
    // 300 matches on ch 0 saturate its counter at 255; clear zeroes it
    do_reset(1);
    cnt_sel = 2'd0;
    for (int n = 0; n < 300; n++) begin
      step(4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0, 0, "cnt_b0");
      step(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b0, 0, "cnt_b1");
      step(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b0, 0, "cnt_b2");
      step(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1, 0, "cnt_b3");
      if (n == 0) begin
        #1 check("cnt_first", 32'(cnt_out), 1);
      end
    end
    #1 check("cnt_sat", 32'(cnt_out), 255);
    cnt_sel = 2'd1;
    #1 check("cnt_other_ch", 32'(cnt_out), 0);
    cnt_sel = 2'd0;
    step(4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b0, 0, "cnt_clr");
    #1 check("cnt_cleared", 32'(cnt_out), 0);
`else
    cnt_sel = 2'd2;
    #1 check("cnt_tied", 32'(cnt_out), 0);
    cnt_sel = 2'd0;
`endif

    idle(3);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL missing_matches: got %0d outstanding, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_det_sched.md
# seq_det_sched

Round-robin scheduler that time-multiplexes one "0111" sequence-detection engine across NCH independent serial channels. Each channel's detector state is held as a saved context and swapped into the shared next-state logic on every granted cycle. The block sits between the serial bit sources and the match-event consumer. It replaces NCH separate detector instances when channel bit rates are low.

## Interface
- NCH, 4, number of serial channels (2..8)
- CHW, 2, channel-id width, must equal ceil(log2(NCH))
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- ch_valid  in  NCH  per-channel: a bit is presented on ch_bit
- ch_bit  in  NCH  per-channel serial data bit
- ch_clr  in  NCH  per-channel context clear
- ch_ready  out  NCH  one-hot grant; a bit is accepted when ch_valid[i] & ch_ready[i]
- match_valid  out  1  registered one-cycle pulse: a pattern completed
- match_ch  out  CHW  channel id of the match, valid with match_valid
- busy  out  1  registered: at least one context is not IDLE
- cnt_sel  in  CHW  counter read select (SEQ_SCHED_CNT_EN only)
- cnt_out  out  8  match count of channel cnt_sel (SEQ_SCHED_CNT_EN only)

## Operation
- Context per channel: 2-bit state with encoding IDLE=0, G0=1, G01=2, G011=3.
- Shared transitions for accepted bit b:
  - IDLE: b=0 -> G0, b=1 -> IDLE
  - G0: b=0 -> G0, b=1 -> G01
  - G01: b=0 -> G0, b=1 -> G011
  - G011: b=0 -> G0, b=1 -> IDLE with match
- Matching is non-overlapping. After a match the context restarts at IDLE.
- Arbitration:
  - Eligible set = ch_valid & ~ch_clr.
  - The grant goes to the first eligible channel found searching upward (with wrap) from ptr.
  - ch_ready is combinational from the eligible set and ptr. It is at most one-hot and zero when nothing is eligible.
- Pointer update: on a grant to channel g, ptr <= (g+1) mod NCH. With no grant, ptr holds.
- Only the granted channel's context updates. All other contexts hold.
- ch_clr[i] forces context i to IDLE on the next edge. Channel i is masked from arbitration that cycle, so no bit is consumed and no match is produced.
- ch_clr on a non-granted channel does not disturb the current grant.
- Reset: all contexts IDLE, ptr=0, match_valid=0, match_ch=0, busy=0, counters 0. ch_ready is then driven purely by the eligibility rules.
- Reset mid-stream discards all partial sequences. No match is reported for any bit accepted in the reset cycle.

## Timing
- Bit accepted at edge t. Context written at edge t. match_valid/match_ch are asserted for the cycle after t, for exactly one cycle per match.
- Back-to-back matches on different channels in consecutive cycles give consecutive match_valid pulses with the correct ids.
- Max throughput: one bit per cycle aggregate. With k channels continuously valid, each is granted once every k cycles.
- busy reflects context state after edge t, i.e. it lags context writes by zero cycles relative to the registered state.
- Starvation-free: a continuously valid, non-cleared channel is granted within NCH cycles.

## Configuration
- SEQ_SCHED_CNT_EN defined:
  - Per-channel 8-bit match counters, incremented with match_valid and saturating at 255.
  - ch_clr[i] zeroes counter i.
  - cnt_out = counter[cnt_sel], combinational.
- SEQ_SCHED_CNT_EN undefined:
  - No counters. cnt_out is tied to 0 and cnt_sel is ignored.

## Test plan
- Reset, then channel 0 alone streams 0,1,1,1 -> ch_ready[0] high each valid cycle; one match_valid with match_ch=0, one cycle after the fourth bit accepted.
- Channels 0..3 all valid continuously, each stream 0,1,1,1 -> grant order 0,1,2,3 repeating; four matches with ids 0,1,2,3 in consecutive cycles.
- Channel 2 streams 0,1,1,1,1,1 -> exactly one match (non-overlap); context IDLE afterwards; busy=0.
- Channel 1 fed 0,1,1, then ch_clr[1] for one cycle, then 1 -> no match; ch_ready[1]=0 during the clear cycle.
- rst asserted after channel 3 fed 0,1,1, then released and fed 1 -> no match; all outputs 0 during reset.
- SEQ_SCHED_CNT_EN: 300 matches on channel 0 -> cnt_out=255 with cnt_sel=0; ch_clr[0] -> cnt_out=0 next cycle.
